// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the board txd line between the CPU MMIO serial port
// and a debug trace source. Round-robin arbiter with debug frame locking,
// baud divider and 8N1 serializer.
// Optional: define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk_50M,
  input  logic       reset_btn,
  input  logic       cpu_valid,
  input  logic [7:0] cpu_data,
  output logic       cpu_ready,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  input  logic       dbg_last,
  output logic       dbg_ready,
  output logic       txd,
  output logic       busy,
  output logic       dbg_lock
);

  localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             lock_q, lock_d;
  logic             last_dbg_q, last_dbg_d;
  logic             grant_cpu, grant_dbg;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end   = (div_q == DIV_LAST);
  assign cpu_ready = grant_cpu;
  assign dbg_ready = grant_dbg;
  assign txd       = txd_q;
  assign busy      = busy_q;
  assign dbg_lock  = lock_q;

  // Grant: only in IDLE; a locked debug frame excludes the CPU, ties alternate.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state_q == IDLE && reset_btn) begin
      if (lock_q) begin
        grant_dbg = dbg_valid;
      end else if (cpu_valid && dbg_valid) begin
        grant_cpu = last_dbg_q;
        grant_dbg = !last_dbg_q;
      end else begin
        grant_cpu = cpu_valid;
        grant_dbg = dbg_valid;
      end
    end
  end

  // Next state, bit timing and the registered line value for the next cycle.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    lock_d     = lock_q;
    last_dbg_d = last_dbg_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        txd_d = 1'b1;
        if (grant_cpu) begin
          shreg_d    = cpu_data;
          last_dbg_d = 1'b0;
          state_d    = START;
          txd_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d      = ^cpu_data;
`endif
        end else if (grant_dbg) begin
          shreg_d    = dbg_data;
          last_dbg_d = 1'b1;
          lock_d     = !dbg_last;
          state_d    = START;
          txd_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d      = ^dbg_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = DATA;
          txd_d   = shreg_q[0];
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            txd_d   = shreg_q[1];
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = STOP;
          txd_d   = 1'b1;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = IDLE;
          txd_d   = 1'b1;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset drops any byte in flight.
  always_ff @(posedge clk_50M or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      lock_q     <= 1'b0;
      last_dbg_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      lock_q     <= lock_d;
      last_dbg_q <= last_dbg_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: a fast-baud instance (10 cycles/bit) carries
// the arbitration tests, a default instance (434 cycles/bit) checks real timing.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int FDIV      = 10;
  localparam int DIV_FULL  = 434;
  localparam int BOUND     = 3000;
`ifdef UART_TX_PARITY_EN
  localparam int NB        = 11;
`else
  localparam int NB        = 10;
`endif

  logic       clk_50M = 1'b0;
  logic       reset_btn;
  logic       cpu_valid, dbg_valid, dbg_last;
  logic [7:0] cpu_data, dbg_data;
  logic       cpu_ready, dbg_ready, txd, busy, dbg_lock;
  logic       f_cpu_valid, f_dbg_valid, f_dbg_last;
  logic [7:0] f_cpu_data, f_dbg_data;
  logic       f_cpu_ready, f_dbg_ready, f_txd, f_busy, f_dbg_lock;

  always #10 clk_50M = ~clk_50M;

  uart_tx_arbiter #(.CLK_FREQ(50000000), .BAUD(5000000)) dut (
    .clk_50M(clk_50M), .reset_btn(reset_btn),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_last(dbg_last), .dbg_ready(dbg_ready),
    .txd(txd), .busy(busy), .dbg_lock(dbg_lock)
  );

  uart_tx_arbiter dut_full (
    .clk_50M(clk_50M), .reset_btn(reset_btn),
    .cpu_valid(f_cpu_valid), .cpu_data(f_cpu_data), .cpu_ready(f_cpu_ready),
    .dbg_valid(f_dbg_valid), .dbg_data(f_dbg_data), .dbg_last(f_dbg_last), .dbg_ready(f_dbg_ready),
    .txd(f_txd), .busy(f_busy), .dbg_lock(f_dbg_lock)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  // Reference model: frame countdown, grant rules, expected-byte queue.
  int         m_cnt = 0;
  bit         m_lock = 1'b0;
  bit         m_last_dbg = 1'b1;
  bit         m_acc_cpu = 1'b0;
  bit         m_acc_dbg = 1'b0;
  logic [7:0] exp_q[$];
  bit         mon_active = 1'b0;
  int         mon_k = 0;
  int         mon_bad = 0;
  logic [7:0] mon_byte = 8'h00;

  typedef struct {
    logic       cv;
    logic [7:0] cd;
    logic       dv;
    logic [7:0] dd;
    logic       dl;
    logic       ecr;
    logic       edr;
    logic       elock;
  } vec_t;
  vec_t tab[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Sample at the falling edge, run line monitor and model for the fast DUT.
  task automatic sample();
    bit g_cpu, g_dbg;
    @(negedge clk_50M);
    cyc_n++;
    m_acc_cpu = 1'b0;
    m_acc_dbg = 1'b0;
    if (!reset_btn) begin
      m_cnt = 0; m_lock = 1'b0; m_last_dbg = 1'b1;
      exp_q.delete(); mon_active = 1'b0;
      chk("reset_outputs", {txd, busy, dbg_lock, cpu_ready, dbg_ready}, 5'b10000);
    end else begin
      if (!mon_active && txd == 1'b0) begin
        if (exp_q.size() == 0) chk("unexpected_start_bit", 1, 0);
        else begin
          mon_byte = exp_q.pop_front(); mon_active = 1'b1; mon_k = 0; mon_bad = 0;
        end
      end
      if (mon_active) begin
        if (txd !== exp_bit(mon_byte, mon_k / FDIV)) mon_bad++;
        mon_k++;
        if (mon_k == NB * FDIV) begin
          chk($sformatf("frame_%02h_bad_cycles", mon_byte), mon_bad, 0);
          mon_active = 1'b0;
        end
      end
      if (m_cnt > 0) begin
        m_cnt--;
        chk("busy_frame", {busy, dbg_lock, cpu_ready, dbg_ready}, {1'b1, m_lock, 2'b00});
      end else begin
        g_cpu = 1'b0; g_dbg = 1'b0;
        if (m_lock) g_dbg = dbg_valid;
        else if (cpu_valid && dbg_valid) begin g_cpu = m_last_dbg; g_dbg = !m_last_dbg; end
        else begin g_cpu = cpu_valid; g_dbg = dbg_valid; end
        chk("idle", {busy, txd, dbg_lock, cpu_ready, dbg_ready}, {1'b0, 1'b1, m_lock, g_cpu, g_dbg});
        if (g_cpu) begin
          exp_q.push_back(cpu_data); m_last_dbg = 1'b0; m_cnt = NB * FDIV; m_acc_cpu = 1'b1;
        end
        if (g_dbg) begin
          exp_q.push_back(dbg_data); m_last_dbg = 1'b1; m_lock = !dbg_last;
          m_cnt = NB * FDIV; m_acc_dbg = 1'b1;
        end
      end
    end
  endtask

  // Move to just after the next rising edge; accepted requesters drop valid.
  task automatic advance();
    @(posedge clk_50M);
    #1;
    if (m_acc_cpu) cpu_valid = 1'b0;
    if (m_acc_dbg) dbg_valid = 1'b0;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_cnt > 0 && n < BOUND) begin step(); n++; end
    if (m_cnt > 0) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_acc(input bit want_dbg, output int at);
    int n = 0;
    bit got = 1'b0;
    at = -1;
    while (!got && n < BOUND) begin
      sample();
      n++;
      got = want_dbg ? m_acc_dbg : m_acc_cpu;
      if (got) at = cyc_n;
      advance();
    end
    if (!got) chk(want_dbg ? "dbg_accept_timeout" : "cpu_accept_timeout", 0, 1);
  endtask

  task automatic send_cpu(input logic [7:0] d, output int at);
    cpu_data = d; cpu_valid = 1'b1;
    wait_acc(1'b0, at);
  endtask

  task automatic send_dbg(input logic [7:0] d, input logic l, output int at);
    dbg_data = d; dbg_last = l; dbg_valid = 1'b1;
    wait_acc(1'b1, at);
  endtask

  initial begin
    int bad, t0, t1, t2, n;
    cpu_valid = 0; cpu_data = 0; dbg_valid = 0; dbg_data = 0; dbg_last = 0;
    f_cpu_valid = 0; f_cpu_data = 0; f_dbg_valid = 0; f_dbg_data = 0; f_dbg_last = 0;
    reset_btn = 1'b0;
    #1;
    repeat (3) step();
    reset_btn = 1'b1;

    // Default-rate instance: idle after reset, then 0x55 with 434-cycle bits.
    bad = 0;
    repeat (1000) begin
      sample();
      if ({f_txd, f_busy, f_dbg_lock, f_cpu_ready, f_dbg_ready} !== 5'b10000) bad++;
      advance();
    end
    chk("full_idle_1000", bad, 0);
    f_cpu_data = 8'h55; f_cpu_valid = 1'b1;
    sample(); chk("full_cpu_ready", f_cpu_ready, 1); advance();
    f_cpu_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < NB * DIV_FULL; k++) begin
      sample();
      if (k == 0) chk("full_ready_pulse", {f_cpu_ready, f_busy}, 2'b01);
      if (f_txd !== exp_bit(8'h55, k / DIV_FULL) || f_busy !== 1'b1) bad++;
      advance();
    end
    chk("full_frame_55", bad, 0);
    sample(); chk("full_busy_drop", {f_busy, f_txd}, 2'b01); advance();

    // Table: arbitration, alternation and debug locking on the fast instance.
    tab[0]  = '{1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[2]  = '{1'b1, 8'h43, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[3]  = '{1'b1, 8'h45, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[4]  = '{1'b1, 8'h45, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab[5]  = '{1'b1, 8'h46, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1};
    tab[6]  = '{1'b1, 8'h46, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1};
    tab[7]  = '{1'b1, 8'h46, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[8]  = '{1'b1, 8'h46, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[9]  = '{1'b1, 8'h46, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[10] = '{1'b0, 8'h00, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[11] = '{1'b1, 8'h47, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      cpu_valid = tab[i].cv; cpu_data = tab[i].cd;
      dbg_valid = tab[i].dv; dbg_data = tab[i].dd; dbg_last = tab[i].dl;
      sample();
      chk($sformatf("tab%0d_ready", i), {cpu_ready, dbg_ready}, {tab[i].ecr, tab[i].edr});
      advance();
      sample(); chk($sformatf("tab%0d_lock", i), dbg_lock, tab[i].elock); advance();
      wait_idle();
    end

    // Parity-relevant bytes (even parity 1 and 0 when enabled).
    send_cpu(8'h07, t0); wait_idle();
    send_cpu(8'h03, t0); wait_idle();

    // Locked debug frame with a long gap while the CPU keeps requesting.
    cpu_data = 8'h5A; cpu_valid = 1'b1;
    send_dbg(8'hA0, 1'b0, t0);
    send_dbg(8'hA1, 1'b0, t1);
    chk("dbg_back_to_back", t1 - t0, NB * FDIV + 1);
    wait_idle();
    bad = 0;
    repeat (5000) begin
      sample();
      if ({dbg_lock, cpu_ready, txd} !== 3'b101) bad++;
      advance();
    end
    chk("lock_gap", bad, 0);
    send_dbg(8'hA2, 1'b1, t1);
    wait_acc(1'b0, t2);
    chk("cpu_after_frame", t2 - t1, NB * FDIV + 1);
    wait_idle();

    // Reset in the middle of data bit 3, then a clean byte.
    send_cpu(8'hF0, t0);
    repeat (4 * FDIV + FDIV / 2) step();
    sample();
    chk("bit3_low_before_reset", txd, 0);
    reset_btn = 1'b0;
    #1;
    chk("async_reset_txd", {txd, busy, dbg_lock}, 3'b100);
    advance();
    repeat (3) step();
    reset_btn = 1'b1;
    send_cpu(8'h0F, t0);
    wait_idle();

    // Random traffic against the model.
    for (int c = 0; c < 20000; c++) begin
      if (!cpu_valid && $urandom_range(0, 7) == 0) begin
        cpu_valid = 1'b1; cpu_data = 8'($urandom);
      end
      if (!dbg_valid && $urandom_range(0, 5) == 0) begin
        dbg_valid = 1'b1; dbg_data = 8'($urandom); dbg_last = ($urandom_range(0, 2) == 0);
      end
      step();
    end
    n = 0;
    while ((cpu_valid || dbg_valid || m_lock || m_cnt > 0) && n < 4 * BOUND) begin
      if (m_lock && !dbg_valid) begin
        dbg_valid = 1'b1; dbg_data = 8'($urandom); dbg_last = 1'b1;
      end
      step();
      n++;
    end
    chk("drain_done", {cpu_valid, dbg_valid, m_lock}, 3'b000);
    wait_idle();
    step();
    chk("queue_empty", exp_q.size() + int'(mon_active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
